// File: rtl/obstacle_engine.sv
// obstacle_engine: per-lane obstacle spawn/scroll/retire with collision, score and pixel mask
module obstacle_engine #(
  parameter int LANE_X0   = 120,
  parameter int LANE_W    = 80,
  parameter int OBS_W     = 48,
  parameter int OBS_H     = 64,
  parameter int SCREEN_H  = 480,
  parameter int PLAYER_Y  = 400,
  parameter int PLAYER_H  = 64,
  parameter int SPAWN_GAP = 40
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       frame_tick,
  input  logic       enable,
  input  logic [2:0] obstacle_num,
  input  logic [1:0] speed_data0,
  input  logic [1:0] speed_data1,
  input  logic [1:0] speed_data2,
  input  logic [1:0] speed_data3,
  input  logic [1:0] speed_data4,
  input  logic [2:0] player_lane,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic [4:0] car_on,
  output logic [4:0] active,
  output logic       crash,
  output logic [9:0] score
);
  localparam int CW = $clog2(SPAWN_GAP);
  localparam logic [9:0] SCORE_MAX = 10'd999;
  typedef enum logic [1:0] {IDLE, RUN, CRASHED} state_t;
  state_t r_state, w_state_n;
  logic [4:0] r_act, w_act_n, r_car_on, w_car_on, w_retire, w_mv_act, w_ovl, w_spawn;
  logic [9:0] r_y [5];
  logic [9:0] w_y_n [5];
  logic [9:0] w_mv_y [5];
  logic [10:0] w_sum [5];
  logic [2:0] w_d [5];
  logic [1:0] r_spd [5];
  logic [1:0] w_spd_n [5];
  logic [1:0] w_sd [5];
  logic [CW-1:0] r_cnt, w_cnt_n;
  logic [9:0] r_score, w_score_n, w_score_sat;
  logic [10:0] w_score_sum;
  logic [2:0] w_ret;
  logic [7:0] w_act_pad, w_hit_pad, w_spawn_pad;
  logic w_spawn_ok, w_hit;
  assign w_sd = '{speed_data0, speed_data1, speed_data2, speed_data3, speed_data4};
  for (genvar i = 0; i < 5; i++) begin : g_lane
    localparam int XL = LANE_X0 + i * LANE_W + (LANE_W - OBS_W) / 2;
    assign w_d[i]      = (r_spd[i] == 2'd0) ? 3'd2 : {r_spd[i], 1'b0};
    assign w_sum[i]    = {1'b0, r_y[i]} + {8'd0, w_d[i]};
    assign w_retire[i] = r_act[i] && (w_sum[i] >= 11'(SCREEN_H));
    assign w_mv_act[i] = r_act[i] && !w_retire[i];
    assign w_mv_y[i]   = w_mv_act[i] ? w_sum[i][9:0] : r_y[i];
    assign w_ovl[i]    = ({1'b0, w_mv_y[i]} + 11'(OBS_H) > 11'(PLAYER_Y)) &&
                         ({1'b0, w_mv_y[i]} < 11'(PLAYER_Y + PLAYER_H));
    assign w_car_on[i] = (r_state != IDLE) && r_act[i] &&
                         ({1'b0, pixel_x} >= 11'(XL)) && ({1'b0, pixel_x} < 11'(XL + OBS_W)) &&
                         ({1'b0, pixel_y} >= {1'b0, r_y[i]}) &&
                         ({1'b0, pixel_y} < {1'b0, r_y[i]} + 11'(OBS_H));
  end
  // Padding to 8 bits lets out-of-range lane codes 5..7 index harmlessly as zero
  assign w_act_pad   = {3'b0, r_act};
  assign w_hit_pad   = {3'b0, w_mv_act & w_ovl};
  assign w_hit       = w_hit_pad[player_lane];
  assign w_spawn_ok  = (r_cnt == CW'(SPAWN_GAP - 1)) && (obstacle_num <= 3'd4) && !w_act_pad[obstacle_num];
  assign w_spawn_pad = w_spawn_ok ? (8'd1 << obstacle_num) : 8'd0;
  assign w_spawn     = w_spawn_pad[4:0];
  assign w_score_sum = {1'b0, r_score} + {8'd0, w_ret};
  assign w_score_sat = (w_score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : w_score_sum[9:0];
  always_comb begin
    w_ret = '0;
    for (int k = 0; k < 5; k++) w_ret = w_ret + {2'b0, w_retire[k]};
  end
  always_comb begin
    w_state_n = r_state;
    w_act_n   = r_act;
    w_y_n     = r_y;
    w_spd_n   = r_spd;
    w_cnt_n   = r_cnt;
    w_score_n = r_score;
    if (r_state == IDLE || !enable) begin
      w_act_n   = '0;
      w_y_n     = '{default: '0};
      w_spd_n   = '{default: '0};
      w_cnt_n   = '0;
      w_state_n = (r_state == IDLE && enable) ? RUN : IDLE;
      w_score_n = (r_state == IDLE && enable) ? '0 : r_score;
    end else if (r_state == RUN && frame_tick) begin
      for (int k = 0; k < 5; k++) begin
        w_act_n[k] = w_mv_act[k] || w_spawn[k];
        w_y_n[k]   = w_spawn[k] ? '0 : w_mv_y[k];
        w_spd_n[k] = w_spawn[k] ? w_sd[k] : r_spd[k];
      end
      w_cnt_n   = w_spawn_ok ? '0 : (r_cnt == CW'(SPAWN_GAP - 1)) ? r_cnt : r_cnt + 1'b1;
      w_score_n = w_score_sat;
      w_state_n = w_hit ? CRASHED : RUN;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_act    <= '0;
      r_y      <= '{default: '0};
      r_spd    <= '{default: '0};
      r_cnt    <= '0;
      r_score  <= '0;
      r_car_on <= '0;
    end else begin
      r_state  <= w_state_n;
      r_act    <= w_act_n;
      r_y      <= w_y_n;
      r_spd    <= w_spd_n;
      r_cnt    <= w_cnt_n;
      r_score  <= w_score_n;
      r_car_on <= w_car_on;
    end
  end
  assign car_on = r_car_on;
  assign active = r_act;
  assign crash  = (r_state == CRASHED);
  assign score  = r_score;
endmodule
